// File: rtl/fc_layer_ctrl_pkg.sv
// Shared types and helpers for the fc_layer sequencer: FSM states, host opcodes,
// packed weight-address layout and error-flag bit positions.
package fc_layer_pkg;

  localparam int unsigned WADDR_IN_W  = 7;
  localparam int unsigned WADDR_OUT_W = 4;
  localparam int unsigned WADDR_W     = WADDR_IN_W + WADDR_OUT_W;

  localparam int unsigned ERR_LAST_BIT    = 0;
  localparam int unsigned ERR_TIMEOUT_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_B,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_INFER = 1'b1
  } cmd_op_e;

  function automatic logic [WADDR_W-1:0] pack_waddr(
    input logic [WADDR_IN_W-1:0]  in_idx,
    input logic [WADDR_OUT_W-1:0] out_idx
  );
    return {in_idx, out_idx};
  endfunction

endpackage

// File: rtl/fc_layer_ctrl_if.sv
// Sequencer <-> fc_layer bus: mode/start handshake, weight and bias write ports,
// activation vector and result return.
interface fc_layer_ctrl_if #(
  parameter int unsigned INPUT_SIZE  = 100,
  parameter int unsigned OUTPUT_SIZE = 10,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IN_IDX_W    = 7,
  parameter int unsigned OUT_IDX_W   = 4
);

  logic                              lyr_mode_o;
  logic                              lyr_valid_o;
  logic                              lyr_ready_i;
  logic [INPUT_SIZE*DATA_WIDTH-1:0]  lyr_input_o;
  logic [IN_IDX_W+OUT_IDX_W-1:0]     lyr_waddr_o;
  logic [DATA_WIDTH-1:0]             lyr_wdata_o;
  logic                              lyr_we_o;
  logic [IN_IDX_W+OUT_IDX_W-1:0]     lyr_baddr_o;
  logic [DATA_WIDTH-1:0]             lyr_bdata_o;
  logic                              lyr_bwe_o;
  logic                              lyr_done_i;
  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] lyr_out_i;

  modport master (
    output lyr_mode_o, lyr_valid_o, lyr_input_o,
    output lyr_waddr_o, lyr_wdata_o, lyr_we_o,
    output lyr_baddr_o, lyr_bdata_o, lyr_bwe_o,
    input  lyr_ready_i, lyr_done_i, lyr_out_i
  );

  modport slave (
    input  lyr_mode_o, lyr_valid_o, lyr_input_o,
    input  lyr_waddr_o, lyr_wdata_o, lyr_we_o,
    input  lyr_baddr_o, lyr_bdata_o, lyr_bwe_o,
    output lyr_ready_i, lyr_done_i, lyr_out_i
  );

endinterface

// File: rtl/fc_layer_watchdog.sv
// Cycle counter with clear and enable; tc_o pulses while enabled at count TIMEOUT_CYCLES-1.
module fc_layer_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == TC_VAL);

  // Saturates at the terminal value so tc_o cannot wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Host-side sequencer for one fc_layer: streams weights/biases on LOAD, runs one
// inference on INFER, and returns the captured result over valid/ready.
module fc_layer_ctrl
  import fc_layer_pkg::*;
#(
  parameter int unsigned INPUT_SIZE     = 100,
  parameter int unsigned OUTPUT_SIZE    = 10,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned IN_IDX_W       = WADDR_IN_W,
  parameter int unsigned OUT_IDX_W      = WADDR_OUT_W,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  logic                              cmd_op_i,
  input  logic [INPUT_SIZE*DATA_WIDTH-1:0]  act_data_i,
  input  logic                              cfg_valid_i,
  output logic                              cfg_ready_o,
  input  logic [DATA_WIDTH-1:0]             cfg_data_i,
  input  logic                              cfg_last_i,
  fc_layer_ctrl_if.master                   lyr,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] res_data_o,
  output logic                              busy_o,
  output logic [1:0]                        err_o
);

  localparam int unsigned ADDR_W = IN_IDX_W + OUT_IDX_W;
  localparam logic [IN_IDX_W-1:0]  IN_LAST  = IN_IDX_W'(INPUT_SIZE - 1);
  localparam logic [OUT_IDX_W-1:0] OUT_LAST = OUT_IDX_W'(OUTPUT_SIZE - 1);

  state_e                            state_q, state_d;
  logic [IN_IDX_W-1:0]               in_idx_q, in_idx_d;
  logic [OUT_IDX_W-1:0]              out_idx_q, out_idx_d;
  logic [INPUT_SIZE*DATA_WIDTH-1:0]  act_q, act_d;
  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] res_q, res_d;
  logic [1:0]                        err_q, err_d;

  logic              we, bwe, mode, start;
  logic [ADDR_W-1:0] waddr, baddr;
  logic [DATA_WIDTH-1:0] wdata, bdata;
  logic              wd_clr, wd_en, wd_tc;
  logic              out_wrap, w_last;

  assign out_wrap = (out_idx_q == OUT_LAST);
  assign w_last   = out_wrap && (in_idx_q == IN_LAST);

  fc_layer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clr_i (wd_clr),
    .en_i  (wd_en),
    .tc_o  (wd_tc)
  );

  always_comb begin
    state_d     = state_q;
    in_idx_d    = in_idx_q;
    out_idx_d   = out_idx_q;
    act_d       = act_q;
    res_d       = res_q;
    err_d       = err_q;
    cmd_ready_o = 1'b0;
    cfg_ready_o = 1'b0;
    res_valid_o = 1'b0;
    mode        = 1'b0;
    start       = 1'b0;
    we          = 1'b0;
    bwe         = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          err_d = '0;
          if (cmd_op_e'(cmd_op_i) == OP_INFER) begin
            act_d   = act_data_i;
            state_d = ST_ISSUE;
          end else begin
            in_idx_d  = '0;
            out_idx_d = '0;
            state_d   = ST_LOAD_W;
          end
        end
      end
      // A premature cfg_last still writes its word, then aborts the stream.
      ST_LOAD_W: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          we = 1'b1;
          if (cfg_last_i) begin
            err_d[ERR_LAST_BIT] = 1'b1;
            state_d             = ST_IDLE;
          end else if (w_last) begin
            in_idx_d  = '0;
            out_idx_d = '0;
            state_d   = ST_LOAD_B;
          end else if (out_wrap) begin
            out_idx_d = '0;
            in_idx_d  = in_idx_q + 1'b1;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      ST_LOAD_B: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) begin
          bwe = 1'b1;
          if (out_wrap) begin
            if (!cfg_last_i) err_d[ERR_LAST_BIT] = 1'b1;
            state_d = ST_IDLE;
          end else if (cfg_last_i) begin
            err_d[ERR_LAST_BIT] = 1'b1;
            state_d             = ST_IDLE;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        mode   = 1'b1;
        start  = 1'b1;
        wd_clr = 1'b1;
        if (lyr.lyr_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        mode  = 1'b1;
        wd_en = 1'b1;
        if (lyr.lyr_done_i) begin
          res_d   = lyr.lyr_out_i;
          state_d = ST_RESP;
        end else if (wd_tc) begin
          err_d[ERR_TIMEOUT_BIT] = 1'b1;
          state_d                = ST_IDLE;
        end
      end
      ST_RESP: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    waddr = we  ? pack_waddr(in_idx_q, out_idx_q) : '0;
    wdata = we  ? cfg_data_i : '0;
    baddr = bwe ? {{IN_IDX_W{1'b0}}, out_idx_q} : '0;
    bdata = bwe ? cfg_data_i : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      act_q     <= '0;
      res_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      act_q     <= act_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  assign lyr.lyr_mode_o  = mode;
  assign lyr.lyr_valid_o = start;
  assign lyr.lyr_input_o = act_q;
  assign lyr.lyr_waddr_o = waddr;
  assign lyr.lyr_wdata_o = wdata;
  assign lyr.lyr_we_o    = we;
  assign lyr.lyr_baddr_o = baddr;
  assign lyr.lyr_bdata_o = bdata;
  assign lyr.lyr_bwe_o   = bwe;

  assign res_data_o = res_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign err_o      = err_q;

endmodule
